// File: rtl/spec_frame_capture.sv
// Captures one 1024-bin power-spectrum frame into a dual-port buffer with a windowed peak search.
// Optional PEAK_THRESH_EN adds a peak_thresh input and peak_found flag.
module spec_frame_capture #(
  parameter int unsigned N_LOG2 = 10,
  parameter int unsigned DW     = 32,
  parameter int unsigned BIN_LO = 1,
  parameter int unsigned BIN_HI = 511
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     power_spec,
  input  logic [N_LOG2-1:0] data_index,
  input  logic              data_valid,
  input  logic              frame_ack,
  input  logic [N_LOG2-1:0] rd_addr,
`ifdef PEAK_THRESH_EN
  input  logic [DW-1:0]     peak_thresh,
  output logic              peak_found,
`endif
  output logic [DW-1:0]     rd_data,
  output logic              frame_ready,
  output logic              peak_valid,
  output logic [N_LOG2-1:0] peak_bin,
  output logic [DW-1:0]     peak_val,
  output logic [7:0]        seq_err_cnt,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned Depth = 1 << N_LOG2;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StHold    = 2'd2;

  localparam logic [N_LOG2-1:0] LastIdx = {N_LOG2{1'b1}};
  localparam logic [N_LOG2-1:0] BinLo   = N_LOG2'(BIN_LO);
  localparam logic [N_LOG2-1:0] BinHi   = N_LOG2'(BIN_HI);

  logic [DW-1:0] mem [Depth];

  logic [1:0]        state_q, state_d;
  logic [N_LOG2-1:0] expected_q, expected_d;
  logic [DW-1:0]     max_val_q, max_val_d;
  logic [N_LOG2-1:0] max_bin_q, max_bin_d;
  logic [7:0]        seq_err_q, seq_err_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              frame_ready_q, frame_ready_d;
  logic              peak_valid_q, peak_valid_d;
  logic [N_LOG2-1:0] peak_bin_q, peak_bin_d;
  logic [DW-1:0]     peak_val_q, peak_val_d;

  logic wr_en;
  logic in_win;
  logic is_first;
  logic start;

  assign in_win   = (data_index >= BinLo) && (data_index <= BinHi);
  assign is_first = data_valid && (data_index == '0);
  // A new frame may start from IDLE, or from HOLD when the reader releases on the same cycle.
  assign start    = is_first && ((state_q == StIdle) || ((state_q == StHold) && frame_ack));

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    max_val_d     = max_val_q;
    max_bin_d     = max_bin_q;
    seq_err_d     = seq_err_q;
    overrun_d     = overrun_q;
    frame_ready_d = frame_ready_q;
    peak_valid_d  = 1'b0;
    peak_bin_d    = peak_bin_q;
    peak_val_d    = peak_val_q;
    wr_en         = 1'b0;

    if (start) begin
      wr_en         = 1'b1;
      expected_d    = N_LOG2'(1);
      state_d       = StCapture;
      frame_ready_d = 1'b0;
      if (in_win) begin
        max_val_d = power_spec;
        max_bin_d = data_index;
      end else begin
        max_val_d = '0;
        max_bin_d = BinLo;
      end
    end else begin
      case (state_q)
        StCapture: begin
          if (data_valid) begin
            if (data_index == expected_q) begin
              wr_en      = 1'b1;
              expected_d = expected_q + N_LOG2'(1);
              if (in_win && (power_spec > max_val_q)) begin
                max_val_d = power_spec;
                max_bin_d = data_index;
              end
              if (data_index == LastIdx) begin
                state_d       = StHold;
                frame_ready_d = 1'b1;
                peak_valid_d  = 1'b1;
                peak_bin_d    = max_bin_d;
                peak_val_d    = max_val_d;
              end
            end else begin
              // Out-of-order sample: drop the partial frame without writing it.
              state_d = StIdle;
              if (seq_err_q != 8'hff) seq_err_d = seq_err_q + 8'd1;
            end
          end
        end
        StHold: begin
          if (frame_ack) begin
            state_d       = StIdle;
            frame_ready_d = 1'b0;
          end else if (is_first && (overrun_q != 8'hff)) begin
            overrun_d = overrun_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      expected_q    <= '0;
      max_val_q     <= '0;
      max_bin_q     <= '0;
      seq_err_q     <= '0;
      overrun_q     <= '0;
      frame_ready_q <= 1'b0;
      peak_valid_q  <= 1'b0;
      peak_bin_q    <= '0;
      peak_val_q    <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      max_val_q     <= max_val_d;
      max_bin_q     <= max_bin_d;
      seq_err_q     <= seq_err_d;
      overrun_q     <= overrun_d;
      frame_ready_q <= frame_ready_d;
      peak_valid_q  <= peak_valid_d;
      peak_bin_q    <= peak_bin_d;
      peak_val_q    <= peak_val_d;
    end
  end

  // Buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[data_index] <= power_spec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef PEAK_THRESH_EN
  logic peak_found_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               peak_found_q <= 1'b0;
    else if (peak_valid_d) peak_found_q <= (max_val_d >= peak_thresh);
  end

  assign peak_found = peak_found_q;
`endif

  assign frame_ready = frame_ready_q;
  assign peak_valid  = peak_valid_q;
  assign peak_bin    = peak_bin_q;
  assign peak_val    = peak_val_q;
  assign seq_err_cnt = seq_err_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_spec_frame_capture.sv
// Randomized self-checking bench for spec_frame_capture against a frame-level reference model.
module tb_spec_frame_capture;
  localparam int N      = 1024;
  localparam int BIN_LO = 1;
  localparam int BIN_HI = 511;

  logic        clk, rst;
  logic [31:0] power_spec;
  logic [9:0]  data_index;
  logic        data_valid, frame_ack;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_ready, peak_valid;
  logic [9:0]  peak_bin;
  logic [31:0] peak_val;
  logic [7:0]  seq_err_cnt, overrun_cnt;
`ifdef PEAK_THRESH_EN
  logic [31:0] peak_thresh;
  logic        peak_found;
`endif

  spec_frame_capture dut (
    .clk         (clk),
    .rst         (rst),
    .power_spec  (power_spec),
    .data_index  (data_index),
    .data_valid  (data_valid),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
`ifdef PEAK_THRESH_EN
    .peak_thresh (peak_thresh),
    .peak_found  (peak_found),
`endif
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .peak_valid  (peak_valid),
    .peak_bin    (peak_bin),
    .peak_val    (peak_val),
    .seq_err_cnt (seq_err_cnt),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pv_cnt = 0;

  logic [31:0] fv   [N];  // frame being sent
  logic [31:0] held [N];  // expected buffer contents while held
  int          exp_bin;
  logic [31:0] exp_val;

  always @(negedge clk) if (peak_valid === 1'b1) pv_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input logic [31:0] val);
    data_valid = v;
    data_index = idx[9:0];
    power_spec = val;
    tick();
  endtask

  task automatic ref_peak(output int b, output logic [31:0] v);
    v = 0;
    b = BIN_LO;
    for (int i = BIN_LO; i <= BIN_HI; i++) if (fv[i] > v) begin v = fv[i]; b = i; end
  endtask

  task automatic send_frame(input int gap_pct, input logic ack_first, input logic expect_cap);
    int pv0;
    pv0 = pv_cnt;
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) drive(0, $urandom, $urandom);
      frame_ack = ack_first && (i == 0);
      drive(1, i, fv[i]);
      frame_ack = 1'b0;
      if (ack_first && i == 0) check("ack_restart_ready_low", frame_ready, 0);
    end
    data_valid = 1'b0;
    if (expect_cap) begin
      ref_peak(exp_bin, exp_val);
      for (int i = 0; i < N; i++) held[i] = fv[i];
      check("peak_valid_pulse", peak_valid, 1);
      check("frame_ready_set", frame_ready, 1);
      check("peak_bin", peak_bin, exp_bin);
      check("peak_val", peak_val, exp_val);
`ifdef PEAK_THRESH_EN
      check("peak_found", peak_found, exp_val >= peak_thresh);
`endif
      tick();
      check("peak_valid_drop", peak_valid, 0);
      check("peak_pulse_count", pv_cnt - pv0, 1);
    end else begin
      tick();
    end
  endtask

  task automatic release_frame();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("frame_ready_fall", frame_ready, 0);
  endtask

  task automatic read_check(input string tag, input int addr);
    rd_addr = addr[9:0];
    tick();
    check(tag, rd_data, held[addr]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_peak_valid"}, peak_valid, 0);
    check({tag, "_peak_bin"}, peak_bin, 0);
    check({tag, "_peak_val"}, peak_val, 0);
    check({tag, "_seq_err"}, seq_err_cnt, 0);
    check({tag, "_overrun"}, overrun_cnt, 0);
`ifdef PEAK_THRESH_EN
    check({tag, "_peak_found"}, peak_found, 0);
`endif
  endtask

  initial begin
    int pv0;
    rst = 1'b1; data_valid = 0; data_index = 0; power_spec = 0; frame_ack = 0; rd_addr = 0;
`ifdef PEAK_THRESH_EN
    peak_thresh = 32'd600;
`endif
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Contiguous ramp frame
    for (int i = 0; i < N; i++) fv[i] = i;
    send_frame(0, 0, 1);
    check("ramp_bin_511", peak_bin, 511);
    check("ramp_val_511", peak_val, 511);
    read_check("ramp_rd_700", 700);
    check("ramp_rd_700_const", rd_data, 700);
    release_frame();

    // Tie at 37/200, big DC bin, random gaps
    for (int i = 0; i < N; i++) fv[i] = 0;
    fv[37] = 1000; fv[200] = 1000; fv[0] = 5000;
    send_frame(30, 0, 1);
    check("tie_bin_37", peak_bin, 37);
    check("tie_val_1000", peak_val, 1000);
    read_check("tie_rd_0", 0);
    release_frame();

    // Mid-frame join at index 300
    for (int i = 300; i < N; i++) drive(1, i, $urandom);
    data_valid = 0;
    check("midjoin_no_ready", frame_ready, 0);
    for (int i = 0; i < N; i++) fv[i] = $urandom;
    send_frame(10, 0, 1);
    check("midjoin_seq_err", seq_err_cnt, 0);
    for (int k = 0; k < 3; k++) read_check("rand_rd", $urandom_range(N - 1));
    release_frame();

    // Small-valued random frame: many ties
    for (int i = 0; i < N; i++) fv[i] = $urandom_range(15);
    send_frame(20, 0, 1);
    release_frame();

    // Out-of-order abort
    pv0 = pv_cnt;
    for (int i = 0; i < 100; i++) drive(1, i, $urandom);
    drive(1, 101, 32'hffff_ffff);
    data_valid = 0;
    check("abort_seq_err", seq_err_cnt, 1);
    check("abort_not_ready", frame_ready, 0);
    drive(1, 102, 0);  // ignored in IDLE
    data_valid = 0;
    tick();
    check("abort_idle_seq_err", seq_err_cnt, 1);
    check("abort_no_pulse", pv_cnt - pv0, 0);
    for (int i = 0; i < N; i++) fv[i] = $urandom;
    send_frame(15, 0, 1);

    // Overrun while holding
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) fv[i] = $urandom;
      send_frame(10, 0, 0);
    end
    check("overrun_cnt_2", overrun_cnt, 2);
    check("overrun_still_ready", frame_ready, 1);
    check("overrun_peak_bin_hold", peak_bin, exp_bin);
    check("overrun_peak_val_hold", peak_val, exp_val);
    for (int k = 0; k < 4; k++) read_check("overrun_rd_stable", $urandom_range(N - 1));

    // Ack with index 0 on same cycle; all-zero frame reports BIN_LO/0
    for (int i = 0; i < N; i++) fv[i] = 0;
    send_frame(10, 1, 1);
    check("restart_overrun_kept", overrun_cnt, 2);
    check("zero_bin_lo", peak_bin, BIN_LO);
    check("zero_val", peak_val, 0);
    release_frame();

    // Threshold frames: peak 511 then 800
    for (int i = 0; i < N; i++) fv[i] = i;
    send_frame(0, 0, 1);
`ifdef PEAK_THRESH_EN
    check("thresh_511_not_found", peak_found, 0);
`endif
    release_frame();
    for (int i = 0; i < N; i++) fv[i] = $urandom_range(500);
    fv[50] = 800;
    send_frame(5, 0, 1);
    check("thresh_800_bin", peak_bin, 50);
`ifdef PEAK_THRESH_EN
    check("thresh_800_found", peak_found, 1);
`endif

    // Asynchronous reset mid-capture
    release_frame();
    rd_addr = 10'd50;
    for (int i = 0; i <= 50; i++) drive(1, i, 32'h1234_0000 + i);
    data_valid = 0;
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) fv[i] = $urandom;
    send_frame(10, 0, 1);
    check("post_reset_seq_err", seq_err_cnt, 0);
    check("post_reset_overrun", overrun_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spec_frame_capture.md
Name: spec_frame_capture

Overview:
- Receiving end of the power-spectrum stream: consumes `(power_spec, data_index, data_valid)` and captures one full 1024-bin frame into an internal dual-port buffer.
- Runs a peak search over a configurable bin window while capturing.
- Holds the frame stable for a downstream range-bin / host reader until acknowledged.
- Sits directly after the power-spectrum calculator in the FFT processing chain.

Parameters:
- N_LOG2, 10, log2 of frame length (bins per frame = 2^N_LOG2)
- DW, 32, power sample width
- BIN_LO, 1, first bin included in peak search (skips DC)
- BIN_HI, 511, last bin included in peak search (positive-frequency half)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- power_spec  in  DW  power value of current bin
- data_index  in  N_LOG2  bin index of power_spec
- data_valid  in  1  power_spec/data_index valid this cycle
- frame_ack  in  1  reader finished with held frame; release buffer
- rd_addr  in  N_LOG2  buffer read address
- rd_data  out  DW  buffer read data, 1-cycle latency
- frame_ready  out  1  complete frame held in buffer
- peak_valid  out  1  one-cycle pulse: peak_bin/peak_val updated
- peak_bin  out  N_LOG2  bin of maximum power within [BIN_LO, BIN_HI]
- peak_val  out  DW  maximum power value
- seq_err_cnt  out  8  saturating count of aborted (out-of-order) frames
- overrun_cnt  out  8  saturating count of frames dropped while holding

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; running max/bin 0; expected index 0.
  - Buffer contents are not reset.
- Reset is asynchronous. Reset mid-capture discards the partial frame; counters clear.
- Write path: on an accepted sample, mem[data_index] <= power_spec in the same cycle. Only CAPTURE, or the IDLE entry sample, writes.
- Read path: rd_data <= mem[rd_addr] every clock, independent of state.
  - Contents are guaranteed consistent only while frame_ready=1.
  - Read and write use separate ports. A same-address read during a write returns the old data.
- FSM states:
  - IDLE:
    - data_valid with data_index != 0 is ignored (mid-frame join).
    - data_valid with data_index == 0: write the sample, expected <= 1, running max initialised from it (if 0 lies in the window, else cleared), go to CAPTURE.
  - CAPTURE:
    - Cycles with data_valid=0 are permitted gaps; nothing changes.
    - data_valid with data_index == expected: write the sample, update the running max, expected++.
    - data_valid with data_index != expected: abort, seq_err_cnt++ (saturates at 255), go to IDLE. The aborting sample is not written.
    - Accepted sample with data_index == 2^N_LOG2-1: go to HOLD.
  - HOLD:
    - frame_ready=1; buffer writes are blocked.
    - Each data_valid with data_index == 0 increments overrun_cnt (saturating); that frame is dropped.
    - frame_ack=1 returns to IDLE. If that same cycle has data_valid with index 0, the sample is accepted and the FSM goes straight to CAPTURE instead; no overrun is counted.
    - frame_ack outside HOLD is ignored.
- Peak search:
  - Update only when BIN_LO <= index <= BIN_HI and power_spec > running max (strictly greater, unsigned). Ties keep the lowest bin.
  - If no bin in the window exceeds 0, report peak_bin=BIN_LO, peak_val=0.
- Peak timing:
  - On the cycle after the last-bin write (HOLD entry), peak_bin/peak_val load from the running max and peak_valid pulses for 1 cycle.
  - peak_bin/peak_val then hold until the next completed frame.
- frame_ready rises on the same cycle as peak_valid and falls the cycle after frame_ack.
- Latency: last sample in -> peak_valid = 1 clk.
- Arithmetic: compare is full DW-bit unsigned; no truncation.

Optional Feature:
- Macro: PEAK_THRESH_EN.
- With the macro defined:
  - Extra input port peak_thresh [DW-1:0] and extra output port peak_found [1].
  - peak_found is set with peak_valid as (peak_val >= peak_thresh) and resets to 0.
  - peak_bin/peak_val are still reported unchanged.
- Without the macro: neither port exists; peak_valid alone signals frame completion.

Test Plan:
- Contiguous frame, power_spec = index, data_valid=1 for 1024 cycles -> frame_ready=1 and one peak_valid pulse 1 clk after index 1023; peak_bin=511, peak_val=511; a read of rd_addr=700 returns 700 one clk later.
- Frame with value 1000 at bins 37 and 200 (0 elsewhere), random data_valid gaps -> peak_bin=37, peak_val=1000; a value of 5000 at bin 0 does not affect the peak.
- Stream starts at index 300 -> ignored until the next index 0; capture completes normally and seq_err_cnt=0.
- Index sequence 0..99 then 101 -> abort, seq_err_cnt=1, state IDLE, frame_ready stays 0; the next clean frame completes.
- Hold frame without frame_ack while two more frames arrive -> overrun_cnt=2 and buffer contents unchanged. Then assert frame_ack together with index 0 valid -> capture restarts with no extra overrun count.
- PEAK_THRESH_EN with peak_thresh=600: frame peaking at 511 -> peak_found=0; frame peaking at 800 -> peak_found=1. Assert rst mid-capture -> all outputs return to 0 immediately.
